// File: rtl/reg_window_pkg.sv
// Shared definitions for the register-window controller: controller states,
// frame-pointer and shift widths, window size and the default nesting depth.
package reg_window_pkg;

   localparam int FP_W                = 4;
   localparam int SHIFT_W             = 3;
   localparam int WIN_SIZE            = 8;
   localparam int DEFAULT_STACK_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MOVE   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_FAULT  = 2'd3
   } state_e;

endpackage

// File: rtl/regwin_shift_stack.sv
// LIFO of CALL shift amounts. The top entry tells a RTN how far to move the
// frame pointer back. Pushes into a full stack and pops from an empty one
// are ignored; the controller flags those cases itself.
module regwin_shift_stack
   import reg_window_pkg::*;
#(
   parameter int DEPTH = DEFAULT_STACK_DEPTH
)
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [SHIFT_W-1:0] data_i,
   output logic               full_o,
   output logic               empty_o,
   output logic [SHIFT_W-1:0] top_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0]      count_q, count_d;
   logic [CW-1:0]      top_idx;
   logic [SHIFT_W-1:0] slots [DEPTH];

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign top_idx = count_q - CW'(1);
   assign top_o   = slots[top_idx[PW-1:0]];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         logic [SHIFT_W-1:0] slot_q;
         // A slot captures the pushed amount when it is the next free position
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               slot_q <= '0;
            end else if (push_i && !full_o && (count_q == CW'(gi))) begin
               slot_q <= data_i;
            end
         end
         assign slots[gi] = slot_q;
      end
   endgenerate

   // Occupancy follows accepted pushes and pops
   always_comb begin
      count_d = count_q;
      if (push_i && !full_o) begin
         count_d = count_q + CW'(1);
      end else if (pop_i && !empty_o) begin
         count_d = count_q - CW'(1);
      end
   end

   // Occupancy register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/reg_window_ctrl.sv
// Register-window controller: maps window-relative register selects onto a
// 16-entry physical file through the frame pointer, and moves the window on
// CALL/RTN with a MOVE cycle followed by a SETTLE cycle.
// Optional feature macro: REGWIN_FAULT_TRAP_EN -- stack errors and CALLs whose
// window would run past physical register 15 trap into a sticky FAULT state.
// Without it, stack errors give a one-cycle Fault pulse and windows wrap.
module reg_window_ctrl
   import reg_window_pkg::*;
#(
   parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
)
(
   input  logic               Clock,
   input  logic               Reset_n,
   input  logic               Call_Req,
   input  logic               Rtn_Req,
   input  logic [SHIFT_W-1:0] Shift_I,
   input  logic [2:0]         Rd_Sel,
   input  logic [2:0]         Rs_Sel,
   input  logic [2:0]         Rm_Sel,
   input  logic               Rd_We,
   input  logic               Rs_We,
   output logic [FP_W-1:0]    Rd_Addr,
   output logic [FP_W-1:0]    Rs_Addr,
   output logic [FP_W-1:0]    Rm_Addr,
   output logic [2:0]         Actual_Rd,
   output logic [2:0]         Actual_Rs,
   output logic [2:0]         Actual_Rm,
   output logic               Rd_Wen,
   output logic               Rs_Wen,
   output logic [FP_W-1:0]    New_FP,
   output logic               FP_move,
   output logic               FP_push_up,
   output logic               Busy,
   output logic               Fault
);

   state_e              state_q, state_d;
   logic [FP_W-1:0]     fp_q, fp_d;
   logic [FP_W-1:0]     new_fp_q, new_fp_d;
   logic                push_up_q, push_up_d;
   logic                err;
   logic                stk_push, stk_pop, stk_full, stk_empty;
   logic [SHIFT_W-1:0]  stk_top;

`ifdef REGWIN_FAULT_TRAP_EN
   logic [FP_W:0]       win_end;
   // Last physical register the new window would cover, without wrapping
   assign win_end = {1'b0, fp_q} + {2'b0, Shift_I} + (FP_W+1)'(WIN_SIZE - 1);
`else
   logic                fault_q;
`endif

   regwin_shift_stack #(
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk_i   (Clock),
      .rst_ni  (Reset_n),
      .push_i  (stk_push),
      .pop_i   (stk_pop),
      .data_i  (Shift_I),
      .full_o  (stk_full),
      .empty_o (stk_empty),
      .top_o   (stk_top)
   );

   assign Rd_Addr    = fp_q + {1'b0, Rd_Sel};
   assign Rs_Addr    = fp_q + {1'b0, Rs_Sel};
   assign Rm_Addr    = fp_q + {1'b0, Rm_Sel};
   assign Actual_Rd  = Rd_Sel;
   assign Actual_Rs  = Rs_Sel;
   assign Actual_Rm  = Rm_Sel;
   assign New_FP     = (state_q == ST_MOVE) ? new_fp_q : fp_q;
   assign FP_push_up = push_up_q;
   assign Busy       = (state_q != ST_IDLE);
`ifdef REGWIN_FAULT_TRAP_EN
   assign Fault      = (state_q == ST_FAULT);
`else
   assign Fault      = fault_q;
`endif

   // Request acceptance, window-move sequencing and write-enable gating
   always_comb begin
      state_d   = state_q;
      fp_d      = fp_q;
      new_fp_d  = new_fp_q;
      push_up_d = push_up_q;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      err       = 1'b0;
      FP_move   = 1'b0;
      Rd_Wen    = 1'b0;
      Rs_Wen    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            Rd_Wen = Rd_We;
            Rs_Wen = Rs_We;
            // CALL has priority; a simultaneous RTN is dropped even when the
            // CALL itself turns out to be a zero-shift no-op
            if (Call_Req) begin
               if (Shift_I != '0) begin
                  if (stk_full) begin
                     err = 1'b1;
`ifdef REGWIN_FAULT_TRAP_EN
                  end else if (win_end > (FP_W+1)'(2**FP_W - 1)) begin
                     err = 1'b1;
`endif
                  end else begin
                     stk_push  = 1'b1;
                     new_fp_d  = fp_q + {1'b0, Shift_I};
                     push_up_d = 1'b1;
                     state_d   = ST_MOVE;
                  end
               end
            end else if (Rtn_Req) begin
               if (stk_empty) begin
                  err = 1'b1;
               end else begin
                  stk_pop   = 1'b1;
                  new_fp_d  = fp_q - {1'b0, stk_top};
                  push_up_d = 1'b0;
                  state_d   = ST_MOVE;
               end
            end
`ifdef REGWIN_FAULT_TRAP_EN
            if (err) begin
               state_d = ST_FAULT;
            end
`endif
         end
         ST_MOVE: begin
            // Only the link-register write is allowed while the window moves
            FP_move = 1'b1;
            Rd_Wen  = Rd_We;
            fp_d    = new_fp_q;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            state_d = ST_IDLE;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller state, frame pointer and pending move target
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= ST_IDLE;
         fp_q      <= '0;
         new_fp_q  <= '0;
         push_up_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         fp_q      <= fp_d;
         new_fp_q  <= new_fp_d;
         push_up_q <= push_up_d;
      end
   end

`ifndef REGWIN_FAULT_TRAP_EN
   // One-cycle error pulse following a rejected CALL or RTN
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= err;
      end
   end
`endif

endmodule

// File: tb/tb_reg_window_ctrl.sv
`timescale 1ns/1ps
module tb_reg_window_ctrl;

   localparam int DEPTH = 4;

   logic       Clock = 1'b0;
   logic       Reset_n = 1'b0;
   logic       Call_Req = 1'b0, Rtn_Req = 1'b0;
   logic [2:0] Shift_I = '0;
   logic [2:0] Rd_Sel = '0, Rs_Sel = '0, Rm_Sel = '0;
   logic       Rd_We = 1'b0, Rs_We = 1'b0;
   logic [3:0] Rd_Addr, Rs_Addr, Rm_Addr, New_FP;
   logic [2:0] Actual_Rd, Actual_Rs, Actual_Rm;
   logic       Rd_Wen, Rs_Wen, FP_move, FP_push_up, Busy, Fault;

   reg_window_ctrl #(.STACK_DEPTH(DEPTH)) dut (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .Call_Req   (Call_Req),
      .Rtn_Req    (Rtn_Req),
      .Shift_I    (Shift_I),
      .Rd_Sel     (Rd_Sel),
      .Rs_Sel     (Rs_Sel),
      .Rm_Sel     (Rm_Sel),
      .Rd_We      (Rd_We),
      .Rs_We      (Rs_We),
      .Rd_Addr    (Rd_Addr),
      .Rs_Addr    (Rs_Addr),
      .Rm_Addr    (Rm_Addr),
      .Actual_Rd  (Actual_Rd),
      .Actual_Rs  (Actual_Rs),
      .Actual_Rm  (Actual_Rm),
      .Rd_Wen     (Rd_Wen),
      .Rs_Wen     (Rs_Wen),
      .New_FP     (New_FP),
      .FP_move    (FP_move),
      .FP_push_up (FP_push_up),
      .Busy       (Busy),
      .Fault      (Fault)
   );

   always #5 Clock = ~Clock;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, exp);
      end
   endtask

   // One cycle: drive at the falling edge, sample 1 ns later
   task automatic drive(input logic call, input logic rtn, input logic [2:0] shift);
      @(negedge Clock);
      Call_Req = call;
      Rtn_Req  = rtn;
      Shift_I  = shift;
      #1;
   endtask

   task automatic do_reset();
      @(negedge Clock);
      Reset_n  = 1'b0;
      Call_Req = 1'b0;
      Rtn_Req  = 1'b0;
      #2;
      Reset_n  = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       call, rtn;
      logic [2:0] shift, rd_sel;
      logic       rd_we, rs_we;
      int         e_fp, e_new_fp;
      logic       e_move, e_up, e_busy, e_fault, e_rd_wen, e_rs_wen;
   } vec_t;

   localparam int NV = 11;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic c, input logic r, input logic [2:0] sh,
                               input logic [2:0] rd, input logic rdwe, input logic rswe,
                               input int fp, input int nfp, input logic mv, input logic up,
                               input logic bsy, input logic flt, input logic rdw, input logic rsw);
      vec_t v;
      v.call = c; v.rtn = r; v.shift = sh; v.rd_sel = rd; v.rd_we = rdwe; v.rs_we = rswe;
      v.e_fp = fp; v.e_new_fp = nfp; v.e_move = mv; v.e_up = up; v.e_busy = bsy;
      v.e_fault = flt; v.e_rd_wen = rdw; v.e_rs_wen = rsw;
      return v;
   endfunction

   // ---------------- reference model ----------------
   int  m_fp, m_phase, m_tgt;
   bit  m_up, m_pulse, m_trap;
   int  m_stk [$];

   task automatic m_reset();
      m_fp = 0; m_phase = 0; m_tgt = 0; m_up = 0; m_pulse = 0; m_trap = 0;
      m_stk.delete();
   endtask

   // Advance the model across one rising edge
   task automatic m_step(input bit call, input bit rtn, input int sh);
      bit err;
      err = 0;
      m_pulse = 0;
      if (m_trap) return;
      if (m_phase == 1) begin
         m_fp = m_tgt;
         m_phase = 2;
      end else if (m_phase == 2) begin
         m_phase = 0;
      end else if (call) begin
         if (sh != 0) begin
            if (m_stk.size() == DEPTH) err = 1;
`ifdef REGWIN_FAULT_TRAP_EN
            else if (m_fp + sh + 7 > 15) err = 1;
`endif
            else begin
               m_stk.push_back(sh);
               m_tgt = (m_fp + sh) % 16;
               m_up = 1;
               m_phase = 1;
            end
         end
      end else if (rtn) begin
         if (m_stk.size() == 0) err = 1;
         else begin
            m_tgt = (m_fp - m_stk.pop_back() + 16) % 16;
            m_up = 0;
            m_phase = 1;
         end
      end
      if (err) begin
`ifdef REGWIN_FAULT_TRAP_EN
         m_trap = 1;
`else
         m_pulse = 1;
`endif
      end
   endtask

   initial begin
      logic [31:0] got_v, exp_v;
      bit          rst_now;
      bit          e_rdw, e_rsw, e_busy;

      // Reset state while Reset_n is held low
      #3;
      chk("rst_busy", Busy, 0);
      chk("rst_fault", Fault, 0);
      chk("rst_move", FP_move, 0);
      chk("rst_newfp", New_FP, 0);
      chk("rst_rdaddr", Rd_Addr, 0);
      #4 Reset_n = 1'b1;

      // ---------------- table-driven sequence ----------------
      tbl[0] = mk(0,0,0,3,1,1, 0,0,0,0,0,0,1,1);
      tbl[1] = mk(1,0,4,3,1,0, 0,0,0,0,0,0,1,0);
      tbl[2] = mk(1,0,2,3,1,1, 0,4,1,1,1,0,1,0);
      tbl[3] = mk(1,0,2,3,1,1, 4,4,0,0,1,0,0,0);
      tbl[4] = mk(0,0,0,3,0,1, 4,4,0,0,0,0,0,1);
      tbl[5] = mk(0,1,0,6,1,1, 4,4,0,0,0,0,1,1);
      tbl[6] = mk(0,0,0,6,0,1, 4,0,1,0,1,0,0,0);
      tbl[7] = mk(0,0,0,6,1,1, 0,0,0,0,1,0,0,0);
      tbl[8] = mk(0,1,0,1,0,0, 0,0,0,0,0,0,0,0);
`ifdef REGWIN_FAULT_TRAP_EN
      tbl[9]  = mk(0,0,0,1,1,1, 0,0,0,0,1,1,0,0);
      tbl[10] = mk(0,0,0,2,1,0, 0,0,0,0,1,1,0,0);
`else
      tbl[9]  = mk(0,0,0,1,1,1, 0,0,0,0,0,1,1,1);
      tbl[10] = mk(0,0,0,2,1,0, 0,0,0,0,0,0,1,0);
`endif
      do_reset();
      for (int i = 0; i < NV; i++) begin
         @(negedge Clock);
         Call_Req = tbl[i].call;
         Rtn_Req  = tbl[i].rtn;
         Shift_I  = tbl[i].shift;
         Rd_Sel   = tbl[i].rd_sel;
         Rs_Sel   = tbl[i].rd_sel + 3'd1;
         Rm_Sel   = tbl[i].rd_sel + 3'd5;
         Rd_We    = tbl[i].rd_we;
         Rs_We    = tbl[i].rs_we;
         #1;
         chk($sformatf("v%0d_rd_addr", i), Rd_Addr, (tbl[i].e_fp + int'(Rd_Sel)) % 16);
         chk($sformatf("v%0d_rs_addr", i), Rs_Addr, (tbl[i].e_fp + int'(Rs_Sel)) % 16);
         chk($sformatf("v%0d_rm_addr", i), Rm_Addr, (tbl[i].e_fp + int'(Rm_Sel)) % 16);
         chk($sformatf("v%0d_actual", i), {Actual_Rd, Actual_Rs, Actual_Rm}, {Rd_Sel, Rs_Sel, Rm_Sel});
         chk($sformatf("v%0d_new_fp", i), New_FP, tbl[i].e_new_fp);
         chk($sformatf("v%0d_fp_move", i), FP_move, tbl[i].e_move);
         if (tbl[i].e_move) chk($sformatf("v%0d_push_up", i), FP_push_up, tbl[i].e_up);
         chk($sformatf("v%0d_busy", i), Busy, tbl[i].e_busy);
         chk($sformatf("v%0d_fault", i), Fault, tbl[i].e_fault);
         chk($sformatf("v%0d_rd_wen", i), Rd_Wen, tbl[i].e_rd_wen);
         chk($sformatf("v%0d_rs_wen", i), Rs_Wen, tbl[i].e_rs_wen);
      end
      Rd_We = 1'b0; Rs_We = 1'b0;

      // ---------------- stack overflow after four nested CALLs ----------------
      do_reset();
      Rd_Sel = 3'd0;
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, 3'd1);
         drive(0, 0, 3'd0);
         drive(0, 0, 3'd0);
      end
      drive(0, 0, 3'd0);
      chk("ovf_fp_before", Rd_Addr, 4);
      chk("ovf_busy_before", Busy, 0);
      drive(1, 0, 3'd1);
      drive(0, 0, 3'd0);
      chk("ovf_fault", Fault, 1);
      chk("ovf_no_move", FP_move, 0);
      chk("ovf_fp_kept", Rd_Addr, 4);
      drive(0, 0, 3'd0);
`ifdef REGWIN_FAULT_TRAP_EN
      chk("ovf_fault_sticky", Fault, 1);
      chk("ovf_busy_trap", Busy, 1);
`else
      chk("ovf_fault_pulse_end", Fault, 0);
      chk("ovf_busy_idle", Busy, 0);
`endif
      chk("ovf_fp_kept2", Rd_Addr, 4);

      // ---------------- CALL beats simultaneous RTN; zero shift is a no-op ----------------
      do_reset();
      drive(1, 1, 3'd2);
      drive(0, 0, 3'd0);
      chk("both_move", FP_move, 1);
      chk("both_up", FP_push_up, 1);
      chk("both_new_fp", New_FP, 2);
      chk("both_no_fault", Fault, 0);
      drive(0, 0, 3'd0);
      drive(0, 0, 3'd0);
      chk("both_fp", Rd_Addr, 2);
      drive(1, 0, 3'd0);
      drive(0, 0, 3'd0);
      chk("zero_busy", Busy, 0);
      chk("zero_move", FP_move, 0);
      chk("zero_fault", Fault, 0);
      chk("zero_fp", Rd_Addr, 2);

      // ---------------- reset during MOVE ----------------
      drive(1, 0, 3'd5);
      drive(0, 0, 3'd0);
      chk("abort_in_move", FP_move, 1);
      chk("abort_target", New_FP, 7);
      #1 Reset_n = 1'b0;
      #1;
      chk("abort_move_drop", FP_move, 0);
      chk("abort_busy", Busy, 0);
      chk("abort_fp", Rd_Addr, 0);
      chk("abort_new_fp", New_FP, 0);
      @(posedge Clock);
      #2 Reset_n = 1'b1;
      drive(0, 0, 3'd0);
      drive(0, 0, 3'd0);
      chk("abort_fp_after", Rd_Addr, 0);
      chk("abort_busy_after", Busy, 0);

      // ---------------- window past physical 15 ----------------
      do_reset();
      drive(1, 0, 3'd6);
      drive(0, 0, 3'd0);
      drive(0, 0, 3'd0);
      drive(1, 0, 3'd6);
      drive(0, 0, 3'd0);
`ifdef REGWIN_FAULT_TRAP_EN
      chk("wrap_trap_fault", Fault, 1);
      chk("wrap_trap_busy", Busy, 1);
      chk("wrap_trap_fp", Rd_Addr, 6);
`else
      drive(0, 0, 3'd0);
      drive(0, 0, 3'd0);
      chk("wrap_fp12", Rd_Addr, 12);
      drive(1, 0, 3'd6);
      drive(0, 0, 3'd0);
      chk("wrap_move", FP_move, 1);
      chk("wrap_new_fp", New_FP, 2);
      chk("wrap_up", FP_push_up, 1);
      chk("wrap_no_fault", Fault, 0);
`endif

      // ---------------- randomized run against the model ----------------
      do_reset();
      m_reset();
      for (int i = 0; i < 1500; i++) begin
         @(negedge Clock);
         rst_now  = ($urandom_range(0, 59) == 0);
         Reset_n  = !rst_now;
         Call_Req = ($urandom_range(0, 2) == 0);
         Rtn_Req  = ($urandom_range(0, 2) == 0);
         Shift_I  = 3'($urandom_range(0, 7));
         Rd_Sel   = 3'($urandom_range(0, 7));
         Rs_Sel   = 3'($urandom_range(0, 7));
         Rm_Sel   = 3'($urandom_range(0, 7));
         Rd_We    = 1'($urandom_range(0, 1));
         Rs_We    = 1'($urandom_range(0, 1));
         if (rst_now) m_reset();
         #1;
         e_busy = (m_phase != 0) || m_trap;
         e_rdw  = !m_trap && (m_phase != 2) && Rd_We;
         e_rsw  = !m_trap && (m_phase == 0) && Rs_We;
         exp_v = {2'b00,
                  4'((m_fp + int'(Rd_Sel)) % 16), 4'((m_fp + int'(Rs_Sel)) % 16),
                  4'((m_fp + int'(Rm_Sel)) % 16), Rd_Sel, Rs_Sel, Rm_Sel,
                  e_rdw, e_rsw, 4'((m_phase == 1) ? m_tgt : m_fp),
                  (m_phase == 1), e_busy, (m_trap || m_pulse)};
         got_v = {2'b00, Rd_Addr, Rs_Addr, Rm_Addr, Actual_Rd, Actual_Rs, Actual_Rm,
                  Rd_Wen, Rs_Wen, New_FP, FP_move, Busy, Fault};
         total++;
         if (got_v != exp_v) begin
            bad++;
            $display("FAIL rand_cycle%0d outputs got=%h want=%h", i, got_v, exp_v);
         end
         if (m_phase == 1) chk($sformatf("rand_up%0d", i), FP_push_up, m_up);
         if (!rst_now) m_step(Call_Req, Rtn_Req, int'(Shift_I));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_window_ctrl.md
REG_WINDOW_CTRL -- requirements
Module: reg_window_ctrl

Interface
REQ-001 Parameter: STACK_DEPTH, default 4, number of nested CALL shift amounts held.
REQ-002 Port: Clock  in  1  single system clock; all state changes on its rising edge.
REQ-003 Port: Reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port: Call_Req / Rtn_Req  in  1 each  window-shift request pulses from the decoder.
REQ-005 Port: Shift_I  in  3  CALL window shift amount, sampled on acceptance.
REQ-006 Port: Rd_Sel / Rs_Sel / Rm_Sel  in  3 each  window-relative register indices.
REQ-007 Port: Rd_We / Rs_We  in  1 each  decoder write enables.
REQ-008 Port: Rd_Addr / Rs_Addr / Rm_Addr  out  4 each  physical register addresses.
REQ-009 Port: Actual_Rd / Actual_Rs / Actual_Rm  out  3 each  window-relative indices to the register file.
REQ-010 Port: Rd_Wen / Rs_Wen  out  1 each  gated write enables.
REQ-011 Port: New_FP  out  4  target frame pointer.
REQ-012 Port: FP_move / FP_push_up  out  1 each  window-move strobe and direction (1 = CALL).
REQ-013 Port: Busy / Fault  out  1 each  move in progress; stack/window error.

Function
REQ-014 FP is a 4-bit register; the window is physical FP..FP+7, modulo 16.
REQ-015 Rx_Addr = FP + Rx_Sel, truncated to 4 bits; Actual_Rx = Rx_Sel, both combinational.
REQ-016 States IDLE, MOVE, SETTLE, FAULT; only IDLE accepts requests.
REQ-017 IDLE: Call_Req with Shift_I != 0 and stack not full -> MOVE, push Shift_I, New_FP = FP + Shift_I, FP_push_up = 1.
REQ-018 IDLE: Rtn_Req with stack not empty -> MOVE, pop I, New_FP = FP - I (mod 16), FP_push_up = 0.
REQ-019 Call_Req and Rtn_Req in the same IDLE cycle: CALL wins; RTN is dropped.
REQ-020 Call_Req with Shift_I = 0: no move, no push, no Fault.
REQ-021 MOVE lasts exactly one cycle: FP_move = 1, New_FP stable, Rd_Wen = Rd_We (CALL link write), Rs_Wen = 0; FP <= New_FP at its end.
REQ-022 SETTLE lasts one cycle: Rd_Wen = Rs_Wen = 0, then -> IDLE.
REQ-023 Latency: request in cycle N -> FP_move in N+1 -> new FP visible in N+2 -> Busy low in N+3.
REQ-024 Busy = 1 in MOVE, SETTLE, FAULT; requests while Busy are ignored, not queued.
REQ-025 In IDLE, Rd_Wen = Rd_We and Rs_Wen = Rs_We; FP_move = 0.
REQ-026 CALL with stack full or RTN with stack empty is an error: no FP change, handled per REQ-031/032.
REQ-027 New_FP equals FP whenever not in MOVE.

Reset
REQ-028 Reset_n low asynchronously forces FP = 0, stack empty, state IDLE, FP_move = 0, Busy = 0, Fault = 0.
REQ-029 Reset during MOVE or SETTLE aborts the move; FP returns to 0, not New_FP.
REQ-030 Reset is the only exit from FAULT.

Configuration
REQ-031 With REGWIN_FAULT_TRAP_EN defined: stack errors, and a CALL whose window would exceed physical 15 (FP + Shift_I + 7 > 15), enter FAULT; Fault sticky high, all write enables 0.
REQ-032 Without REGWIN_FAULT_TRAP_EN: stack errors pulse Fault for one cycle, state stays IDLE; window arithmetic wraps modulo 16 without error.

Structure
REQ-033 Shared package reg_window_pkg holds the state enum, FP width (4), window size (8), and the default STACK_DEPTH.
REQ-034 The shift-amount LIFO is a sub-module, regwin_shift_stack (push, pop, full, empty, top), with an asynchronous active-low reset.

Verification
REQ-035 Reset, then Rd_Sel=3 -> Rd_Addr=3; Call_Req, Shift_I=4 -> FP_move at N+1, New_FP=4, FP_push_up=1; Busy low at N+3; Rd_Sel=3 -> Rd_Addr=7.
REQ-036 From FP=4 with stack [4]: Rtn_Req -> New_FP=0, FP_push_up=0, stack empty.
REQ-037 Four CALLs of Shift_I=1, then a fifth -> Fault (sticky with the macro; one-cycle pulse without it), FP stays 4.
REQ-038 Call_Req and Rtn_Req together in IDLE -> CALL executed; Call_Req repeated during Busy -> ignored.
REQ-039 Reset_n asserted in the MOVE cycle -> FP_move drops immediately, FP=0, Busy=0.
REQ-040 FP=12, Call_Req Shift_I=6 -> FAULT with the macro; New_FP=2 (wrap) without it.
